// File: rtl/opr_fetch.sv
// Operand-read / issue stage.
// Reads two source registers from an async-read register file, tracks outstanding
// destination writes in a per-register scoreboard, stalls on RAW/WAW hazards and
// hands operands to execute through a one-entry valid/ready output register.
//
// Optional build macro: WB_BYPASS_EN
//   defined   - a source matching this cycle's write-back is not stalled and takes wb_wdata
//   undefined - that source waits one more cycle and is read from the register file
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_*                       decoded instruction (valid/ready handshake, in_ready combinational)
//   rf_raddr1/2, rf_rdata1/2   register file read ports (addresses pass straight through)
//   wb_we/waddr/wdata          write-back port; retires scoreboard entries
//   out_*                      registered operands to execute (valid/ready handshake)
//   sb_busy                    at least one write outstanding
module opr_fetch #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DW     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              in_use1,
    input  logic              in_use2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [DW-1:0]     rf_rdata1,
    input  logic [DW-1:0]     rf_rdata2,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_waddr,
    input  logic [DW-1:0]     wb_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_opcode,
    output logic [DW-1:0]     out_oprand1,
    output logic [DW-1:0]     out_oprand2,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_we,
    output logic              sb_busy
);

    localparam int unsigned NREG = 2 ** REG_AW;

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic            clr1;
    logic            clr2;
    logic            raw1;
    logic            raw2;
    logic            waw;
    logic            stall;
    logic            accept;
    logic [DW-1:0]   opr1_sel;
    logic [DW-1:0]   opr2_sel;

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    // Source satisfied by the write-back happening this cycle
`ifdef WB_BYPASS_EN
    assign clr1 = wb_we & (wb_waddr == in_rs1);
    assign clr2 = wb_we & (wb_waddr == in_rs2);
`else
    assign clr1 = 1'b0;
    assign clr2 = 1'b0;
`endif

    // WAW deliberately ignores the same-cycle clear: the new dest waits one cycle
    assign raw1   = in_use1 & pend[in_rs1] & ~clr1;
    assign raw2   = in_use2 & pend[in_rs2] & ~clr2;
    assign waw    = in_we & pend[in_rd];
    assign stall  = in_valid & (raw1 | raw2 | waw);
    assign in_ready = ~stall & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // Regfile read is async and returns pre-write data, so a bypassed source takes wb_wdata
    assign opr1_sel = clr1 ? wb_wdata : rf_rdata1;
    assign opr2_sel = clr2 ? wb_wdata : rf_rdata2;

    // Scoreboard next state: clear on write-back, then set on issue (set wins)
    always_comb begin
        pend_nxt = pend;
        if (wb_we) begin
            pend_nxt[wb_waddr] = 1'b0;
        end
        if (accept && in_we) begin
            pend_nxt[in_rd] = 1'b1;
        end
    end

    // Scoreboard and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            sb_busy <= 1'b0;
        end else begin
            pend    <= pend_nxt;
            sb_busy <= |pend_nxt;
        end
    end

    // One-entry output register; holds while execute back-pressures
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            out_oprand1 <= '0;
            out_oprand2 <= '0;
            out_rd      <= '0;
            out_we      <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_opcode  <= in_opcode;
            out_oprand1 <= opr1_sel;
            out_oprand2 <= opr2_sel;
            out_rd      <= in_rd;
            out_we      <= in_we;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_opr_fetch.sv
// Self-checking bench for opr_fetch: behavioural scoreboard model, expected operand
// bundles queued on accept and compared when the DUT presents them.
module tb_opr_fetch;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_opcode;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic          in_use1;
    logic          in_use2;
    logic [AW-1:0] in_rd;
    logic          in_we;
    logic [AW-1:0] rf_raddr1;
    logic [AW-1:0] rf_raddr2;
    logic [DW-1:0] rf_rdata1;
    logic [DW-1:0] rf_rdata2;
    logic          wb_we;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    out_opcode;
    logic [DW-1:0] out_oprand1;
    logic [DW-1:0] out_oprand2;
    logic [AW-1:0] out_rd;
    logic          out_we;
    logic          sb_busy;

    logic [DW-1:0] rf [32];
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always #5 clk = ~clk;

    opr_fetch #(.REG_AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use1(in_use1), .in_use2(in_use2),
        .in_rd(in_rd), .in_we(in_we),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_oprand1(out_oprand1), .out_oprand2(out_oprand2),
        .out_rd(out_rd), .out_we(out_we), .sb_busy(sb_busy)
    );

    int unsigned   n_cmp = 0;
    int unsigned   n_err = 0;
    int unsigned   n_push = 0;
    int unsigned   n_pop = 0;
    logic [31:0]   m_pend = '0;
    logic          m_ov = 1'b0;
    logic          m_acc = 1'b0;
    logic [95:0]   exp_q [$];

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] out_pack();
        return 96'({out_opcode, out_oprand1, out_oprand2, out_rd, out_we});
    endfunction

    task automatic issue(input logic [5:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic u1, input logic u2, input logic [AW-1:0] rd, input logic we);
        in_valid = 1'b1; in_opcode = op; in_rs1 = rs1; in_rs2 = rs2;
        in_use1 = u1; in_use2 = u2; in_rd = rd; in_we = we;
    endtask

    task automatic wb(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_we = we; wb_waddr = a; wb_wdata = d;
    endtask

    // One clock: predict handshake, score outputs, advance model and regfile
    task automatic tick();
        logic c1, c2, st, rdy, acc;
        logic [31:0] nxt;
        logic [DW-1:0] o1, o2;
        #1;
        c1  = BYP && wb_we && (wb_waddr == in_rs1);
        c2  = BYP && wb_we && (wb_waddr == in_rs2);
        st  = in_valid && ((in_use1 && m_pend[in_rs1] && !c1) ||
                           (in_use2 && m_pend[in_rs2] && !c2) ||
                           (in_we && m_pend[in_rd]));
        rdy = !st && (!m_ov || out_ready);
        check("in_ready", in_ready, rdy);
        acc = in_valid && rdy;
        if (m_ov) begin
            check("q_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                check("out_bundle", out_pack(), exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_pop++;
                end
            end
        end
        if (acc) begin
            o1 = c1 ? wb_wdata : rf[in_rs1];
            o2 = c2 ? wb_wdata : rf[in_rs2];
            exp_q.push_back(96'({in_opcode, o1, o2, in_rd, in_we}));
            n_push++;
        end
        nxt = m_pend;
        if (wb_we) nxt[wb_waddr] = 1'b0;
        if (acc && in_we) nxt[in_rd] = 1'b1;
        @(posedge clk);
        #1;
        if (wb_we) rf[wb_waddr] = wb_wdata;
        m_ov   = acc || (m_ov && !out_ready);
        m_pend = nxt;
        m_acc  = acc;
        check("out_valid", out_valid, m_ov);
        check("sb_busy", sb_busy, |m_pend);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0101_0000 * 32'(i) + 32'(i);
        rf[2] = 32'h11;
        rf[3] = 32'h22;
        rst_n = 1'b0;
        out_ready = 1'b1;
        wb(1'b0, '0, '0);
        issue(6'd1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b0);

        // Reset held with a valid instruction present
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sb_busy", sb_busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_regs", out_pack(), 96'd0);
        rst_n = 1'b1;
        tick();
        check("first_oprand1", out_oprand1, 32'h11);
        check("first_oprand2", out_oprand2, 32'h22);
        in_valid = 1'b0;

        // RAW on rs1 resolved by write-back of r5
        issue(6'd2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
        tick();
        issue(6'd3, 5'd5, 5'd1, 1'b1, 1'b0, 5'd6, 1'b0);
        #1 check("raw_stall", in_ready, 1'b0);
        tick();
        tick();
        wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        #1 check("raw_wb_ready", in_ready, BYP);
        tick();
        lat = 1;
        wb_we = 1'b0;
        if (!m_acc) begin
            tick();
            lat = 2;
        end
        check("raw_latency", 96'(lat), BYP ? 96'd1 : 96'd2);
        check("raw_oprand1", out_oprand1, 32'hDEAD_BEEF);
        in_valid = 1'b0;

        // WAW on r7: same-cycle clear still costs a cycle
        issue(6'd4, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1);
        tick();
        issue(6'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1);
        #1 check("waw_stall", in_ready, 1'b0);
        tick();
        wb(1'b1, 5'd7, 32'h77);
        #1 check("waw_wb_stall", in_ready, 1'b0);
        tick();
        wb_we = 1'b0;
        #1 check("waw_release", in_ready, 1'b1);
        tick();
        check("waw_busy", sb_busy, 1'b1);
        in_valid = 1'b0;
        wb(1'b1, 5'd7, 32'h78);
        tick();
        wb_we = 1'b0;
        tick();
        check("waw_cleared", sb_busy, 1'b0);

        // Back-pressure: output held three cycles, next instruction waits
        issue(6'd6, 5'd2, 5'd3, 1'b1, 1'b1, 5'd8, 1'b0);
        tick();
        out_ready = 1'b0;
        issue(6'd7, 5'd3, 5'd2, 1'b1, 1'b1, 5'd10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_accept", m_acc, 1'b1);
        in_valid = 1'b0;
        tick();
        tick();
        check("bp_balance", 96'(n_pop), 96'(n_push));

        // Set and clear of r4 in the same cycle: set wins
        issue(6'd8, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        issue(6'd9, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1);
        wb(1'b1, 5'd4, 32'h44);
        #1 check("sc_stall", in_ready, 1'b0);
        tick();
        #1 check("sc_ready", in_ready, 1'b1);
        tick();
        wb_we = 1'b0;
        in_valid = 1'b0;
        check("sc_set_wins", sb_busy, 1'b1);
        wb(1'b1, 5'd4, 32'h45);
        tick();
        wb_we = 1'b0;
        tick();

        // Random traffic against the model
        for (int i = 0; i < 120; i++) begin
            int r;
            if (!in_valid || m_acc) begin
                issue(6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 7);
            if (m_pend[r] && ($urandom_range(0, 1) == 1)) wb(1'b1, 5'(r), $urandom);
            else if ($urandom_range(0, 7) == 0) wb(1'b1, 5'(r), $urandom);
            else wb_we = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        wb_we = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rand_balance", 96'(n_pop), 96'(n_push));

        // Asynchronous reset while an output is held and r9 pending
        issue(6'd10, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_sb_busy", sb_busy, 1'b0);
        check("arst_out_regs", out_pack(), 96'd0);
        #2 rst_n = 1'b1;
        m_pend = '0;
        m_ov = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/opr_fetch.md
Name: opr_fetch

Overview:
- Operand-read/issue stage: the read-side counterpart of the write-back path.
- Takes decoded instructions, reads two source registers from the register file and tracks outstanding destination writes in a per-register scoreboard.
- Stalls on RAW/WAW hazards until the write-back port retires the pending write.
- Presents operands to the execute stage through a one-entry valid/ready pipeline register.

Parameters:
- REG_AW, 5, register address width; NREG = 2**REG_AW.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_opcode  in  6  opcode
- in_rs1  in  REG_AW  source 1 address
- in_rs2  in  REG_AW  source 2 address
- in_use1  in  1  instruction reads rs1
- in_use2  in  1  instruction reads rs2
- in_rd  in  REG_AW  destination address
- in_we  in  1  instruction writes rd
- rf_raddr1  out  REG_AW  regfile read address 1 (= in_rs1, combinational)
- rf_raddr2  out  REG_AW  regfile read address 2 (= in_rs2, combinational)
- rf_rdata1  in  DW  regfile async read data 1
- rf_rdata2  in  DW  regfile async read data 2
- wb_we  in  1  write-back strobe
- wb_waddr  in  REG_AW  write-back address
- wb_wdata  in  DW  write-back data
- out_valid  out  1  operands valid
- out_ready  in  1  execute accepts
- out_opcode  out  6  registered opcode
- out_oprand1  out  DW  registered operand 1
- out_oprand2  out  DW  registered operand 2
- out_rd  out  REG_AW  registered destination
- out_we  out  1  registered write flag
- sb_busy  out  1  OR of all scoreboard bits

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0; out_opcode=0; out_oprand1=0; out_oprand2=0; out_rd=0; out_we=0; all scoreboard bits=0 (so sb_busy=0).
- Reset asserted mid-operation discards the held instruction and all pending bits.
- Scoreboard: pend[NREG-1:0]. Register 0 is ordinary (no hardwired zero).
- Hazard terms:
  - raw1 = in_use1 & pend[in_rs1] & !clr1
  - raw2 = in_use2 & pend[in_rs2] & !clr2
  - waw = in_we & pend[in_rd]
  - stall = in_valid & (raw1 | raw2 | waw)
- clrN = WB_BYPASS_EN & wb_we & (wb_waddr == in_rsN). Without the macro, clrN = 0.
- WAW never uses clr: a dest clearing in the same cycle still stalls one cycle.
- in_ready = !stall & (!out_valid | out_ready). Combinational; in_ready does not depend on in_valid except through stall.
- Accept = in_valid & in_ready. On accept, next cycle:
  - out_valid=1;
  - out_opcode, out_rd, out_we captured;
  - out_oprandN = bypass ? wb_wdata : rf_rdataN.
- Latency: exactly 1 cycle from accept to out_valid.
- If out_valid & out_ready & !accept: out_valid→0.
- If out_valid & !out_ready: all out_* hold stable.
- Scoreboard update each cycle:
  - clear pend[wb_waddr] if wb_we;
  - set pend[in_rd] if accept & in_we.
  - Set and clear of the same register in the same cycle: set wins.
- wb_we to a non-pending register: harmless clear; data still goes to the regfile.
- At most one outstanding write per register (guaranteed by the WAW stall).
- Read-after-write to the regfile in the same cycle: the async read returns old data, so only the bypass path (or the stall) yields new data.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: a source matching an active write-back this cycle is not stalled; the operand is taken from wb_wdata.
- Undefined: that source stalls one more cycle and is read from the regfile after the write lands.
- Both builds produce identical architectural operand values.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 → out_valid=0, in_ready follows the reset state, sb_busy=0; release → first instruction (rs1=2, rs2=3, rf data 0x11/0x22) appears next cycle as oprand1=0x11, oprand2=0x22.
- RAW: issue rd=5 we=1, then rs1=5 → in_ready=0 until wb_we with waddr=5, wdata=0xDEAD_BEEF.
  - With the macro: accepted that same cycle, oprand1=0xDEADBEEF.
  - Without it: accepted one cycle later, with rf_rdata1 driven to 0xDEADBEEF.
- WAW: pend[7]=1, issue rd=7 we=1 → stalled; wb_we waddr=7 → accepted next cycle; pend[7]=1 again, sb_busy=1.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and out_* stable; out_ready=1 → next instruction accepted, no loss or duplication.
- Simultaneous set/clear: pend[4]=1 with out_valid=0; in_rd=4, in_we=1 while wb_we waddr=4 → WAW stall one cycle, then accept; pend[4]=1 afterwards.
- Async reset mid-stall: pend[9]=1, out_valid=1, rst_n low for half a cycle → out_valid=0 and sb_busy=0 immediately, without waiting for a clock edge.
